// File: rtl/reg_bank_arbiter.sv
// Register-bank arbiter: serialises one writeback and two operand-read requesters
// onto a toggle-triggered register bank, one access every two cycles.
module reg_bank_arbiter #(
   parameter int unsigned WB_PRIORITY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_req,
   input  logic [3:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        wb_ack,
   input  logic        ra_req,
   input  logic [3:0]  ra_addr,
   output logic        ra_ack,
   output logic [31:0] ra_data,
   input  logic        rb_req,
   input  logic [3:0]  rb_addr,
   output logic        rb_ack,
   output logic [31:0] rb_data,
   output logic [3:0]  bank_addr,
   output logic [31:0] bank_wdata,
   output logic        bank_rw,
   output logic        bank_trigger,
   input  logic [31:0] bank_rdata,
   output logic        busy
);

   typedef enum logic {IDLE, ACCESS} state_e;

   localparam logic [1:0] SEL_WB = 2'd0;
   localparam logic [1:0] SEL_RA = 2'd1;
   localparam logic [1:0] SEL_RB = 2'd2;

   state_e      state_q;
   logic [1:0]  grant_q;
   logic        rdPtr_q;
   logic [1:0]  rrPtr_q;
   logic        wbAck_q;
   logic        raAck_q;
   logic        rbAck_q;
   logic [31:0] raData_q;
   logic [31:0] rbData_q;
   logic [3:0]  bankAddr_q;
   logic [31:0] bankWdata_q;
   logic        bankRw_q;
   logic        bankTrigger_q;

   logic        wbElig;
   logic        raElig;
   logic        rbElig;
   logic [2:0]  elig;
   logic        hazard;
   logic        found;
   logic [1:0]  cand;
   logic [1:0]  grant_d;
   logic        grantValid_d;
   logic [3:0]  selAddr_d;

   function automatic logic [1:0] addMod3(input logic [1:0] a, input logic [1:0] b);
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= 3'd3) begin
         s = s - 3'd3;
      end
      return s[1:0];
   endfunction

   // A requester whose ack is showing this cycle is already served and must not win again.
   // A writer colliding on an address with a reader always goes first so the read sees new data.
   always_comb begin
      wbElig       = wb_req && !wbAck_q;
      raElig       = ra_req && !raAck_q;
      rbElig       = rb_req && !rbAck_q;
      elig         = {rbElig, raElig, wbElig};
      hazard       = wbElig && ((raElig && (ra_addr == wb_addr)) ||
                                (rbElig && (rb_addr == wb_addr)));
      grantValid_d = |elig;
      grant_d      = SEL_WB;
      found        = 1'b0;
      cand         = SEL_WB;
      if (hazard) begin
         grant_d = SEL_WB;
      end else if (WB_PRIORITY != 0) begin
         if (wbElig) begin
            grant_d = SEL_WB;
         end else if (raElig && rbElig) begin
            grant_d = rdPtr_q ? SEL_RB : SEL_RA;
         end else if (raElig) begin
            grant_d = SEL_RA;
         end else begin
            grant_d = SEL_RB;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            cand = addMod3(rrPtr_q, 2'(k));
            if (!found && elig[cand]) begin
               grant_d = cand;
               found   = 1'b1;
            end
         end
      end
      case (grant_d)
         SEL_WB:  selAddr_d = wb_addr;
         SEL_RA:  selAddr_d = ra_addr;
         default: selAddr_d = rb_addr;
      endcase
   end

   // Reset parks the bank in read mode at the same moment the trigger clears, so any
   // trigger edge caused by reset is a harmless read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_q       <= SEL_WB;
         rdPtr_q       <= 1'b0;
         rrPtr_q       <= SEL_WB;
         wbAck_q       <= 1'b0;
         raAck_q       <= 1'b0;
         rbAck_q       <= 1'b0;
         raData_q      <= 32'h0;
         rbData_q      <= 32'h0;
         bankAddr_q    <= 4'h0;
         bankWdata_q   <= 32'h0;
         bankRw_q      <= 1'b1;
         bankTrigger_q <= 1'b0;
      end else begin
         wbAck_q <= 1'b0;
         raAck_q <= 1'b0;
         rbAck_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grantValid_d) begin
                  grant_q       <= grant_d;
                  bankAddr_q    <= selAddr_d;
                  bankRw_q      <= (grant_d != SEL_WB);
                  bankTrigger_q <= ~bankTrigger_q;
                  rrPtr_q       <= addMod3(grant_d, 2'd1);
                  if (grant_d == SEL_WB) begin
                     bankWdata_q <= wb_data;
                  end
                  if (grant_d == SEL_RA) begin
                     rdPtr_q <= 1'b1;
                  end else if (grant_d == SEL_RB) begin
                     rdPtr_q <= 1'b0;
                  end
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               case (grant_q)
                  SEL_WB: wbAck_q <= 1'b1;
                  SEL_RA: begin
                     raAck_q  <= 1'b1;
                     raData_q <= bank_rdata;
                  end
                  default: begin
                     rbAck_q  <= 1'b1;
                     rbData_q <= bank_rdata;
                  end
               endcase
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wb_ack       = wbAck_q;
   assign ra_ack       = raAck_q;
   assign rb_ack       = rbAck_q;
   assign ra_data      = raData_q;
   assign rb_data      = rbData_q;
   assign bank_addr    = bankAddr_q;
   assign bank_wdata   = bankWdata_q;
   assign bank_rw      = bankRw_q;
   assign bank_trigger = bankTrigger_q;
   assign busy         = (state_q == ACCESS);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: one instance with writeback priority, one pure round-robin,
// each attached to a toggle-driven bank model; acks and bank accesses are scoreboarded.
module tb_reg_bank_arbiter;

   localparam int WB = 0;
   localparam int RA = 1;
   localparam int RB = 2;

   typedef struct { int port; logic [3:0] addr; logic [31:0] data; } reqItem;
   typedef struct { int port; logic [31:0] data; int cyc; } ackItem;
   typedef struct { logic rw; logic [3:0] addr; logic [31:0] data; } accItem;

   logic        clock = 1'b0;
   logic        rstS     [2];
   logic        reqS     [2][3];
   logic [3:0]  addrS    [2][3];
   logic [31:0] wdataS   [2];
   logic        ackS     [2][3];
   logic [31:0] raData   [2];
   logic [31:0] rbData   [2];
   logic [3:0]  bankAddr [2];
   logic [31:0] bankWdata[2];
   logic [31:0] bankRdata[2];
   logic [1:0]  bankRw;
   logic [1:0]  bankTrig;
   logic [1:0]  busyS;

   int          checks = 0;
   int          failures = 0;
   int          act = 0;
   int          cycCnt = 0;
   int          t0 = 0;
   bit          armT0 = 1'b0;
   bit          flushReq = 1'b0;
   bit          bankArmed = 1'b0;
   bit          testDone = 1'b0;
   int          accCount [2];
   logic [31:0] mem      [2][16];
   logic [31:0] shadow   [2][16];
   reqItem      rqWb[$];
   reqItem      rqRa[$];
   reqItem      rqRb[$];
   ackItem      expAck[$];
   accItem      expAcc[$];

   always #5 clock = ~clock;

   always @(posedge clock) cycCnt <= cycCnt + 1;

   reg_bank_arbiter #(.WB_PRIORITY(1)) dut (
      .clk(clock), .rst(rstS[0]),
      .wb_req(reqS[0][0]), .wb_addr(addrS[0][0]), .wb_data(wdataS[0]), .wb_ack(ackS[0][0]),
      .ra_req(reqS[0][1]), .ra_addr(addrS[0][1]), .ra_ack(ackS[0][1]), .ra_data(raData[0]),
      .rb_req(reqS[0][2]), .rb_addr(addrS[0][2]), .rb_ack(ackS[0][2]), .rb_data(rbData[0]),
      .bank_addr(bankAddr[0]), .bank_wdata(bankWdata[0]), .bank_rw(bankRw[0]),
      .bank_trigger(bankTrig[0]), .bank_rdata(bankRdata[0]), .busy(busyS[0])
   );

   reg_bank_arbiter #(.WB_PRIORITY(0)) dutRr (
      .clk(clock), .rst(rstS[1]),
      .wb_req(reqS[1][0]), .wb_addr(addrS[1][0]), .wb_data(wdataS[1]), .wb_ack(ackS[1][0]),
      .ra_req(reqS[1][1]), .ra_addr(addrS[1][1]), .ra_ack(ackS[1][1]), .ra_data(raData[1]),
      .rb_req(reqS[1][2]), .rb_addr(addrS[1][2]), .rb_ack(ackS[1][2]), .rb_data(rbData[1]),
      .bank_addr(bankAddr[1]), .bank_wdata(bankWdata[1]), .bank_rw(bankRw[1]),
      .bank_trigger(bankTrig[1]), .bank_rdata(bankRdata[1]), .busy(busyS[1])
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // Queues one request and the bank access plus ack it must produce, in service order.
   task automatic applyStimulus(input int p, input logic [3:0] addr, input logic [31:0] data,
                                input int relCyc, input bit expectAck);
      reqItem r;
      ackItem a;
      accItem x;
      r.port = p;
      r.addr = addr;
      r.data = data;
      case (p)
         WB:      rqWb.push_back(r);
         RA:      rqRa.push_back(r);
         default: rqRb.push_back(r);
      endcase
      x.rw   = (p != WB);
      x.addr = addr;
      x.data = data;
      expAcc.push_back(x);
      a.port = p;
      a.cyc  = relCyc;
      a.data = (p == WB) ? 32'h0 : shadow[act][addr];
      if (expectAck) expAck.push_back(a);
      if (p == WB) shadow[act][addr] = data;
      accCount[act]++;
   endtask

   task automatic takeNext(input int p, output bit got, output reqItem r);
      got = 1'b0;
      r.port = p;
      r.addr = 4'h0;
      r.data = 32'h0;
      case (p)
         WB:      if (rqWb.size() > 0) begin r = rqWb.pop_front(); got = 1'b1; end
         RA:      if (rqRa.size() > 0) begin r = rqRa.pop_front(); got = 1'b1; end
         default: if (rqRb.size() > 0) begin r = rqRb.pop_front(); got = 1'b1; end
      endcase
   endtask

   task automatic waitIdle(input int maxCyc);
      int n;
      n = 0;
      while ((expAck.size() != 0 || expAcc.size() != 0 ||
              (rqWb.size() + rqRa.size() + rqRb.size()) != 0) && n < maxCyc) begin
         @(posedge clock);
         n++;
      end
      if (n >= maxCyc) checkOutput("waitIdleTimeout", expAck.size(), 0);
      repeat (2) @(posedge clock);
      #2;
   endtask

   // Bank model: every trigger edge is one access, using the bus values just after the edge.
   for (genvar g = 0; g < 2; g++) begin : gBank
      initial begin : model
         accItem e;
         forever begin
            @(bankTrig[g]);
            if (bankArmed) begin
               #1;
               checkOutput("bankInst", g, act);
               if (expAcc.size() == 0) begin
                  checkOutput("bankUnexpectedAccess", {31'h0, bankRw[g]}, 32'hFFFF_FFFF);
               end else begin
                  e = expAcc.pop_front();
                  checkOutput("bankRw", {31'h0, bankRw[g]}, {31'h0, e.rw});
                  checkOutput("bankAddr", {28'h0, bankAddr[g]}, {28'h0, e.addr});
                  if (!e.rw) checkOutput("bankWdata", bankWdata[g], e.data);
               end
               if (bankRw[g] == 1'b0) mem[g][bankAddr[g]] = bankWdata[g];
               else bankRdata[g] = mem[g][bankAddr[g]];
            end
         end
      end
   end

   // Requester driver and ack scoreboard for the active instance.
   initial begin : driver
      reqItem r;
      ackItem e;
      bit     got;
      forever begin
         @(negedge clock);
         if (flushReq) begin
            rqWb.delete();
            rqRa.delete();
            rqRb.delete();
            for (int p = 0; p < 3; p++) reqS[act][p] = 1'b0;
            flushReq = 1'b0;
         end else begin
            if (armT0) begin
               t0 = cycCnt;
               armT0 = 1'b0;
            end
            for (int p = 0; p < 3; p++) begin
               if (ackS[act][p]) begin
                  if (expAck.size() == 0) begin
                     checkOutput("unexpectedAck", p, 32'hFFFF_FFFF);
                  end else begin
                     e = expAck.pop_front();
                     checkOutput("ackPort", p, e.port);
                     if (e.cyc >= 0) checkOutput("ackCycle", cycCnt - t0, e.cyc);
                     if (p == RA) checkOutput("raData", raData[act], e.data);
                     if (p == RB) checkOutput("rbData", rbData[act], e.data);
                  end
                  checkOutput("busyAtAck", {31'h0, busyS[act]}, 0);
                  takeNext(p, got, r);
                  if (got) begin
                     addrS[act][p] = r.addr;
                     if (p == WB) wdataS[act] = r.data;
                  end else begin
                     reqS[act][p] = 1'b0;
                  end
               end else if (!reqS[act][p]) begin
                  takeNext(p, got, r);
                  if (got) begin
                     reqS[act][p]  = 1'b1;
                     addrS[act][p] = r.addr;
                     if (p == WB) wdataS[act] = r.data;
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #50000;
      checkOutput("watchdogDone", {31'h0, testDone}, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : main
      logic trigRef;
      int   n;
      accItem x;
      for (int i = 0; i < 2; i++) begin
         rstS[i]     = 1'b1;
         wdataS[i]   = 32'h0;
         accCount[i] = 0;
         for (int p = 0; p < 3; p++) begin
            reqS[i][p]  = 1'b0;
            addrS[i][p] = 4'h0;
         end
         for (int a = 0; a < 16; a++) begin
            mem[i][a]    = {16'hC0DE, 8'(i), 8'(a)};
            shadow[i][a] = {16'hC0DE, 8'(i), 8'(a)};
         end
      end
      repeat (2) @(negedge clock);
      $display("[TB] reset state");
      for (int i = 0; i < 2; i++) begin
         checkOutput("rstBusy", {31'h0, busyS[i]}, 0);
         checkOutput("rstWbAck", {31'h0, ackS[i][0]}, 0);
         checkOutput("rstRaAck", {31'h0, ackS[i][1]}, 0);
         checkOutput("rstRbAck", {31'h0, ackS[i][2]}, 0);
         checkOutput("rstRaData", raData[i], 0);
         checkOutput("rstRbData", rbData[i], 0);
         checkOutput("rstBankAddr", {28'h0, bankAddr[i]}, 0);
         checkOutput("rstBankWdata", bankWdata[i], 0);
         checkOutput("rstBankRw", {31'h0, bankRw[i]}, 1);
         checkOutput("rstBankTrig", {31'h0, bankTrig[i]}, 0);
      end
      bankArmed = 1'b1;
      #1;
      rstS[0] = 1'b0;
      rstS[1] = 1'b0;
      @(posedge clock);
      #2;

      $display("[TB] single write then read-back on both readers");
      applyStimulus(WB, 4'd5, 32'hDEADBEEF, 2, 1'b1);
      armT0 = 1'b1;
      waitIdle(20);
      applyStimulus(RA, 4'd5, 32'h0, 2, 1'b1);
      armT0 = 1'b1;
      waitIdle(20);
      applyStimulus(RB, 4'd5, 32'h0, 2, 1'b1);
      armT0 = 1'b1;
      waitIdle(20);

      $display("[TB] three-way contention with writeback priority");
      applyStimulus(WB, 4'd3, 32'h3333_3333, 2, 1'b1);
      applyStimulus(RA, 4'd7, 32'h0, 4, 1'b1);
      applyStimulus(RB, 4'd9, 32'h0, 6, 1'b1);
      armT0 = 1'b1;
      waitIdle(30);

      $display("[TB] reader fairness with both held high");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(RA, 4'(k), 32'h0, 2 + 4 * k, 1'b1);
         applyStimulus(RB, 4'(8 + k), 32'h0, 4 + 4 * k, 1'b1);
      end
      armT0 = 1'b1;
      waitIdle(60);

      $display("[TB] idle window");
      trigRef = bankTrig[0];
      repeat (10) begin
         @(negedge clock);
         checkOutput("idleTrig", {31'h0, bankTrig[0]}, {31'h0, trigRef});
         checkOutput("idleBusy", {31'h0, busyS[0]}, 0);
         checkOutput("idleAcks", {29'h0, ackS[0][2], ackS[0][1], ackS[0][0]}, 0);
      end
      checkOutput("raDataHold", raData[0], shadow[0][3]);
      checkOutput("rbDataHold", rbData[0], shadow[0][11]);
      @(posedge clock);
      #2;

      $display("[TB] reset during a write access");
      applyStimulus(WB, 4'd6, 32'hBAD0_0006, 2, 1'b0);
      armT0 = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!busyS[0] && n < 10);
      checkOutput("abortBusy", {31'h0, busyS[0]}, 1);
      #1;
      if ((accCount[0] % 2) == 1) begin
         x.rw   = 1'b1;
         x.addr = 4'h0;
         x.data = 32'h0;
         expAcc.push_back(x);
      end
      accCount[0] = 0;
      rstS[0]  = 1'b1;
      flushReq = 1'b1;
      #2;
      checkOutput("abortTrig", {31'h0, bankTrig[0]}, 0);
      checkOutput("abortRw", {31'h0, bankRw[0]}, 1);
      checkOutput("abortBusyLow", {31'h0, busyS[0]}, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      rstS[0] = 1'b0;
      checkOutput("abortNoAck", {31'h0, ackS[0][0]}, 0);
      @(posedge clock);
      #2;
      applyStimulus(RA, 4'd0, 32'h0, 2, 1'b1);
      armT0 = 1'b1;
      waitIdle(20);

      $display("[TB] round-robin instance: hazard and rotation");
      act = 1;
      applyStimulus(WB, 4'd1, 32'h1111_0001, 2, 1'b1);
      armT0 = 1'b1;
      waitIdle(20);
      applyStimulus(WB, 4'd4, 32'h1234_5678, 2, 1'b1);
      applyStimulus(RA, 4'd4, 32'h0, 4, 1'b1);
      armT0 = 1'b1;
      waitIdle(30);
      applyStimulus(RB, 4'd5, 32'h0, 2, 1'b1);
      applyStimulus(WB, 4'd2, 32'h2222_0002, 4, 1'b1);
      applyStimulus(RA, 4'd3, 32'h0, 6, 1'b1);
      armT0 = 1'b1;
      waitIdle(30);

      testDone = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
